ncpu32k_i_cache: RTL
====================

// Module: ncpu32k_i_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache; responder for the I-MMU's icache_cmd/icache_dout ports.
//  Accepts one physical fetch address per cmd handshake and returns one insn word per dout handshake.
//  Misses refill a whole line from the memory-side burst port. Sits between the I-MMU and the system bus.
// PARAMETERS
//  CACHE_LINES_LOG2  6  log2 number of lines (64)
//  LINE_WORDS_LOG2   2  log2 words per line (4 x 32b = 16B)
// PORTS
//  clk               in   1        clock; all logic on posedge
//  rst               in   1        synchronous, active-high reset
//  icache_cmd_valid  in   1        fetch address presented
//  icache_cmd_ready  out  1        cache accepts address this cycle
//  icache_cmd_addr   in   NCPU_AW  physical byte address, word aligned
//  icache_dout_valid out  1        insn presented
//  icache_dout_ready in   1        consumer accepts insn
//  icache_dout       out  NCPU_IW  insn word
//  icache_inv        in   1        pulse: invalidate all lines
//  mem_cmd_valid     out  1        line refill request
//  mem_cmd_ready     in   1        memory accepts request
//  mem_cmd_addr      out  NCPU_AW  line-aligned refill address
//  mem_dout_valid    in   1        refill beat presented (ascending word order)
//  mem_dout_ready    out  1        cache accepts beat
//  mem_dout          in   NCPU_IW  refill beat data
//  perf_hit_cnt      out  32       hit counter (see CONFIGURATION)
//  perf_miss_cnt     out  32       miss counter
// BEHAVIOUR
//  Addr split: [1:0] ignored; word=[LW+1:2]; index=[LW+CL+1:LW+2]; tag=rest. LW/CL = *_LOG2.
//  Reset: state IDLE, all valid bits 0, icache_cmd_ready=1, icache_dout_valid=0, mem_cmd_valid=0,
//   mem_dout_ready=0, icache_dout=0, counters 0. Reset mid-refill aborts it; no line left valid.
//  FSM: IDLE, LOOKUP, MISS_REQ, REFILL, RELOAD, RESP. At most one request in flight.
//  Cmd handshake (cycle T): addr latched to req_addr; data RAM read at index/word issued; -> LOOKUP.
//  LOOKUP (T+1): hit = valid[idx] & tag match. Hit: dout_valid=1 with RAM data (latency 1).
//   Hit & dout_ready: cmd_ready=1 -> back-to-back hits sustain 1 insn/clk; no new cmd -> IDLE.
//   Hit & ~dout_ready: data captured into hold reg -> RESP; dout stable until handshake.
//   Miss: dout_valid=0 -> MISS_REQ.
//  MISS_REQ: mem_cmd_valid=1, mem_cmd_addr={req tag,index,0s}; held until mem_cmd_ready -> REFILL.
//   valid[idx] cleared on entry (line being overwritten).
//  REFILL: mem_dout_ready=1; each beat written to RAM at {idx,beat_cnt}; beat_cnt LW bits, wraps to 0
//   after last beat. Last beat: tag written, valid[idx]=1 unless inv seen during refill -> RELOAD.
//  RELOAD: RAM re-read at req_addr -> dout_valid next cycle (as LOOKUP hit path, then RESP/IDLE).
//  RESP: dout_valid=1 from hold reg; cmd_ready=dout_ready (accepting next cmd same cycle -> LOOKUP).
//  cmd_ready=0 in MISS_REQ/REFILL/RELOAD. Requester may drop cmd_valid without handshake (cancel).
//  icache_inv: all valid bits 0 next cycle; has priority over a same-cycle refill valid-set; a cmd
//   accepted in the inv cycle looks up post-inv state (miss). In-flight response still delivered.
//  mem_dout_valid outside REFILL is ignored (mem_dout_ready=0).
// CONFIGURATION
//  NCPU_ICACHE_PERF_EN defined: perf_hit_cnt/perf_miss_cnt increment (wrap at 2^32) on each LOOKUP
//   hit/miss; RELOAD not counted. Undefined: both ports tied 0, no counter flops.
// STRUCTURE
//  ncpu32k_config.h: NCPU_AW, NCPU_IW; FSM state encodings as localparams in this file.
//  Sub-module ncpu32k_i_cache_ram: 1R1W sync-read data array, depth 2^(CL+LW), width NCPU_IW,
//   read data valid 1 clk after read enable. Tag/valid arrays stay in flops here.
// TESTING
//  1 Cold fetch 0x100 -> mem_cmd_addr=0x100, 4 beats A0..A3, dout=A0; perf_miss_cnt=1.
//  2 Then fetch 0x104,0x108,0x10C back-to-back, dout_ready=1 -> dout A1,A2,A3 on consecutive clks,
//    no mem_cmd; perf_hit_cnt=3.
//  3 Hit with dout_ready=0 for 5 clks -> dout_valid=1, dout stable, cmd_ready=0, until ready.
//  4 Fetch 0x1100 (same index, other tag) -> refill, then 0x100 misses again (conflict eviction).
//  5 icache_inv asserted during REFILL beat 2 -> response delivered, next fetch of same line misses.
//  6 rst asserted in REFILL -> all outputs at reset values next clk; subsequent fetch misses.

Source files
------------

// File: rtl/ncpu32k_i_cache_pkg.sv
// Shared types and bus widths for the ncpu32k direct-mapped instruction cache.
// The NCPU_ICACHE_PERF_EN macro (see ncpu32k_i_cache.sv) enables the hit/miss counters.
package ncpu32k_i_cache_pkg;

  localparam int NCPU_AW = 32;
  localparam int NCPU_IW = 32;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MISS_REQ = 3'd2,
    S_REFILL   = 3'd3,
    S_RELOAD   = 3'd4,
    S_RESP     = 3'd5
  } ic_state_t;

endpackage

// File: rtl/ncpu32k_i_cache_ram.sv
// 1R1W synchronous-read data array: read data appears one clock after re.
import ncpu32k_i_cache_pkg::*;

module ncpu32k_i_cache_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = NCPU_IW
) (
  input  logic              clk,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ncpu32k_i_cache.sv
// Direct-mapped read-only instruction cache between the I-MMU and the memory burst port.
// Define NCPU_ICACHE_PERF_EN to build the hit/miss performance counters.
import ncpu32k_i_cache_pkg::*;

module ncpu32k_i_cache #(
  parameter int CACHE_LINES_LOG2 = 6,
  parameter int LINE_WORDS_LOG2  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               icache_cmd_valid,
  output logic               icache_cmd_ready,
  input  logic [NCPU_AW-1:0] icache_cmd_addr,
  output logic               icache_dout_valid,
  input  logic               icache_dout_ready,
  output logic [NCPU_IW-1:0] icache_dout,
  input  logic               icache_inv,
  output logic               mem_cmd_valid,
  input  logic               mem_cmd_ready,
  output logic [NCPU_AW-1:0] mem_cmd_addr,
  input  logic               mem_dout_valid,
  output logic               mem_dout_ready,
  input  logic [NCPU_IW-1:0] mem_dout,
  output logic [31:0]        perf_hit_cnt,
  output logic [31:0]        perf_miss_cnt,
  output ic_state_t          dbg_state
);

  localparam int CL    = CACHE_LINES_LOG2;
  localparam int LW    = LINE_WORDS_LOG2;
  localparam int OFF_W = LW + 2;
  localparam int TAG_W = NCPU_AW - CL - OFF_W;
  localparam int LINES = 1 << CL;

  // Every port pair transfers on a cycle where valid & ready are both high; valid never
  // depends on ready from the same side, and a requester may withdraw an unaccepted cmd.
  ic_state_t          state_q, state_d;
  logic [NCPU_AW-1:0] req_addr_q, req_addr_d;
  logic [NCPU_IW-1:0] hold_q, hold_d;
  logic [LW-1:0]      beat_cnt_q, beat_cnt_d;
  logic               inv_seen_q, inv_seen_d;
  logic               force_hit_q, force_hit_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [TAG_W-1:0]   tag_d [LINES];

  logic [CL-1:0]      req_idx;
  logic [LW-1:0]      req_word;
  logic [TAG_W-1:0]   req_tag;
  logic               lookup_hit, cmd_hs, count_hit, count_miss;
  logic               ram_re, ram_we;
  logic [CL+LW-1:0]   ram_raddr, ram_waddr;
  logic [NCPU_IW-1:0] ram_rdata;

  assign req_idx  = req_addr_q[OFF_W +: CL];
  assign req_word = req_addr_q[2 +: LW];
  assign req_tag  = req_addr_q[NCPU_AW-1 -: TAG_W];
  // A freshly refilled line always answers, even if an invalidate kept it from going valid.
  assign lookup_hit = force_hit_q | (valid_q[req_idx] & (tag_q[req_idx] == req_tag));
  assign mem_cmd_addr = {req_addr_q[NCPU_AW-1:OFF_W], {OFF_W{1'b0}}};
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    hold_d      = hold_q;
    beat_cnt_d  = beat_cnt_q;
    inv_seen_d  = inv_seen_q;
    force_hit_d = force_hit_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    icache_cmd_ready  = 1'b0;
    icache_dout_valid = 1'b0;
    icache_dout       = '0;
    mem_cmd_valid     = 1'b0;
    mem_dout_ready    = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = {icache_cmd_addr[OFF_W +: CL], icache_cmd_addr[2 +: LW]};
    ram_we     = 1'b0;
    ram_waddr  = {req_idx, beat_cnt_q};
    count_hit  = 1'b0;
    count_miss = 1'b0;
    cmd_hs     = 1'b0;

    case (state_q)
      S_IDLE: icache_cmd_ready = 1'b1;
      S_LOOKUP: begin
        if (lookup_hit) begin
          icache_dout_valid = 1'b1;
          icache_dout       = ram_rdata;
          icache_cmd_ready  = icache_dout_ready;
          count_hit         = ~force_hit_q;
          force_hit_d       = 1'b0;
          if (icache_dout_ready) begin
            state_d = S_IDLE;
          end else begin
            hold_d  = ram_rdata;
            state_d = S_RESP;
          end
        end else begin
          count_miss       = 1'b1;
          valid_d[req_idx] = 1'b0;
          state_d          = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) begin
          beat_cnt_d = '0;
          state_d    = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_dout_ready = 1'b1;
        if (mem_dout_valid) begin
          ram_we     = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (&beat_cnt_q) begin
            tag_d[req_idx]   = req_tag;
            valid_d[req_idx] = ~inv_seen_q;
            state_d          = S_RELOAD;
          end
        end
      end
      S_RELOAD: begin
        ram_re      = 1'b1;
        ram_raddr   = {req_idx, req_word};
        force_hit_d = 1'b1;
        state_d     = S_LOOKUP;
      end
      S_RESP: begin
        icache_dout_valid = 1'b1;
        icache_dout       = hold_q;
        icache_cmd_ready  = icache_dout_ready;
        if (icache_dout_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cmd_hs = icache_cmd_valid & icache_cmd_ready;
    if (icache_inv && (state_q inside {S_LOOKUP, S_MISS_REQ, S_REFILL})) inv_seen_d = 1'b1;
    if (cmd_hs) begin
      req_addr_d = icache_cmd_addr;
      ram_re     = 1'b1;
      inv_seen_d = 1'b0;
      state_d    = S_LOOKUP;
    end
    if (icache_inv) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      hold_q      <= '0;
      beat_cnt_q  <= '0;
      inv_seen_q  <= 1'b0;
      force_hit_q <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      hold_q      <= hold_d;
      beat_cnt_q  <= beat_cnt_d;
      inv_seen_q  <= inv_seen_d;
      force_hit_q <= force_hit_d;
      valid_q     <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  ncpu32k_i_cache_ram #(
    .ADDR_W(CL + LW),
    .DATA_W(NCPU_IW)
  ) u_ram (
    .clk  (clk),
    .re   (ram_re),
    .raddr(ram_raddr),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(mem_dout),
    .rdata(ram_rdata)
  );

`ifdef NCPU_ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  assign hit_cnt_d  = hit_cnt_q + 32'(count_hit);
  assign miss_cnt_d = miss_cnt_q + 32'(count_miss);

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`else
  logic unused_perf;
  assign unused_perf   = count_hit ^ count_miss;
  assign perf_hit_cnt  = '0;
  assign perf_miss_cnt = '0;
`endif

  logic unused_addr;
  assign unused_addr = ^req_addr_q[1:0];

endmodule
